// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller slice.
//   XLEN       : datapath / PC width
//   SHADOW_W   : width of the wrong-path shadow down-counter
//   COUNT_W    : width of the redirect performance counter
//   ALIGN_MASK : PC bits that must be zero for a legal fetch target
package branch_redirect_ctrl_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned SHADOW_W = 3;
    localparam int unsigned COUNT_W  = 16;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SHADOW = 2'd2
    } redirState_e;

    // True when the low target bits violate 4-byte alignment.
    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return (lowBits & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-resolution / redirect bus between the jump logic and fetch control.
//   master : EX-side driver (resolution, target, stall), observes redirect
//   slave  : the redirect controller
interface branch_redirect_ctrl_if;
    import branch_redirect_ctrl_pkg::*;

    logic               ex_valid;
    logic               should_jump;
    logic [XLEN-1:0]    ex_target;
    logic               stall;
    logic               pc_sel;
    logic [XLEN-1:0]    redirect_pc;
    logic               flush_if_id;
    logic               flush_id_ex;
    logic               misalign;
    logic [COUNT_W-1:0] redirect_count;

    modport master (
        output ex_valid, should_jump, ex_target, stall,
        input  pc_sel, redirect_pc, flush_if_id, flush_id_ex, misalign, redirect_count
    );

    modport slave (
        input  ex_valid, should_jump, ex_target, stall,
        output pc_sel, redirect_pc, flush_if_id, flush_id_ex, misalign, redirect_count
    );
endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Generic saturating up-counter for performance events.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count one event this cycle
//   count    : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences PC redirect and pipeline squash after a taken branch/jump in EX.
// Holds a redirect across stalls and ignores wrong-path resolutions for a
// shadow window of SHADOW_CYCLES unstalled cycles after each redirect.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of branch_redirect_ctrl_if
//              in : ex_valid, should_jump, ex_target, stall
//              out: pc_sel, redirect_pc, flush_if_id, flush_id_ex,
//                   misalign, redirect_count
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned SHADOW_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_ctrl_if.slave bus
);

    localparam logic [SHADOW_W-1:0] SHADOW_LOAD = SHADOW_W'(SHADOW_CYCLES);

    redirState_e         state, stateNext;
    logic [XLEN-1:0]     holdReg, holdNext;
    logic [SHADOW_W-1:0] shadowCnt, shadowNext;

    logic                resolve;
    logic                targetBad;
    logic                pcSel;
    logic [XLEN-1:0]     redirectPc;
    logic                flush;
    logic                misalignPulse;
    logic [COUNT_W-1:0]  redirectCount;

    assign resolve   = bus.ex_valid && bus.should_jump;
    assign targetBad = isMisaligned(bus.ex_target[1:0]);

    // State, hold target and shadow counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            holdReg   <= '0;
            shadowCnt <= '0;
        end else begin
            state     <= stateNext;
            holdReg   <= holdNext;
            shadowCnt <= shadowNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext  = state;
        holdNext   = holdReg;
        shadowNext = shadowCnt;
        case (state)
            IDLE: begin
                if (resolve && !targetBad) begin
                    if (bus.stall) begin
                        holdNext  = bus.ex_target;
                        stateNext = HOLD;
                    end else begin
                        shadowNext = SHADOW_LOAD;
                        stateNext  = SHADOW;
                    end
                end
            end
            HOLD: begin
                if (!bus.stall) begin
                    holdNext   = '0;
                    shadowNext = SHADOW_LOAD;
                    stateNext  = SHADOW;
                end
            end
            SHADOW: begin
                // Counter hitting zero on this edge means IDLE next cycle.
                if (!bus.stall) begin
                    shadowNext = shadowCnt - SHADOW_W'(1);
                    if (shadowCnt <= SHADOW_W'(1)) begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext  = IDLE;
                shadowNext = '0;
            end
        endcase
    end

    // Outputs: combinational so an unstalled redirect lands in the resolving
    // cycle; forced quiet while reset is held.
    always_comb begin
        pcSel         = 1'b0;
        redirectPc    = '0;
        flush         = 1'b0;
        misalignPulse = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (resolve) begin
                        if (targetBad) begin
                            misalignPulse = !bus.stall;
                        end else if (!bus.stall) begin
                            pcSel      = 1'b1;
                            redirectPc = bus.ex_target;
                            flush      = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        pcSel      = 1'b1;
                        redirectPc = holdReg;
                        flush      = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (COUNT_W)
    ) uRedirectCount (
        .clk   (clk),
        .rst   (rst),
        .en    (pcSel),
        .count (redirectCount)
    );

    assign bus.pc_sel         = pcSel;
    assign bus.redirect_pc    = redirectPc;
    assign bus.flush_if_id    = flush;
    assign bus.flush_id_ex    = flush;
    assign bus.misalign       = misalignPulse;
    assign bus.redirect_count = redirectCount;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, randomized run
// against a behavioural model, and a standalone saturation run of sat_counter.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    localparam int unsigned SHADOW = 2;

    logic clk = 1'b0;
    logic rst;
    logic satRst;
    logic satEn;
    logic [15:0] satCount;

    branch_redirect_ctrl_if bus ();

    branch_redirect_ctrl #(.SHADOW_CYCLES(SHADOW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sat_counter #(.WIDTH(16)) satDut (
        .clk   (clk),
        .rst   (satRst),
        .en    (satEn),
        .count (satCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r;
        logic        v;
        logic        j;
        logic [31:0] t;
        logic        st;
        logic        pc;
        logic [31:0] rp;
        logic        fl;
        logic        mis;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input logic j, input logic [31:0] t,
                                input logic st, input logic pc, input logic [31:0] rp,
                                input logic fl, input logic mis, input logic [15:0] cnt);
        vec_t x;
        x.r = r; x.v = v; x.j = j; x.t = t; x.st = st;
        x.pc = pc; x.rp = rp; x.fl = fl; x.mis = mis; x.cnt = cnt;
        return x;
    endfunction

    // Behavioural model: a pending-target queue, shadow cycles left, event count.
    logic [31:0] pendQ[$];
    int          shadowLeft;
    int          modelCount;

    task automatic modelCycle(input logic r, input logic v, input logic j, input logic [31:0] t,
                              input logic st, output logic pc, output logic [31:0] rp,
                              output logic fl, output logic mis, output logic [15:0] cnt);
        logic        doIssue;
        logic [31:0] tgt;
        pc = 0; rp = 0; fl = 0; mis = 0; doIssue = 0; tgt = 0;
        if (r) begin
            pendQ.delete();
            shadowLeft = 0;
            modelCount = 0;
            cnt = 0;
            return;
        end
        cnt = 16'(modelCount);
        if (shadowLeft > 0) begin
            if (!st) shadowLeft--;
        end else if (pendQ.size() > 0) begin
            if (!st) begin
                doIssue = 1;
                tgt = pendQ.pop_front();
            end
        end else if (v && j) begin
            if ((t % 4) != 0) mis = !st;
            else if (!st) begin
                doIssue = 1;
                tgt = t;
            end else pendQ.push_back(t);
        end
        if (doIssue) begin
            pc = 1; rp = tgt; fl = 1;
            shadowLeft = SHADOW;
            if (modelCount < 65535) modelCount++;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic j, input logic [31:0] t, input logic st);
        rst = r;
        bus.ex_valid = v;
        bus.should_jump = j;
        bus.ex_target = t;
        bus.stall = st;
    endtask

    task automatic checkOutputs(input string tag, input logic pc, input logic [31:0] rp,
                                input logic fl, input logic mis, input logic [15:0] cnt);
        check({tag, ".pc_sel"},      32'(bus.pc_sel),         32'(pc));
        check({tag, ".redirect_pc"}, bus.redirect_pc,         rp);
        check({tag, ".flush_if_id"}, 32'(bus.flush_if_id),    32'(fl));
        check({tag, ".flush_id_ex"}, 32'(bus.flush_id_ex),    32'(fl));
        check({tag, ".misalign"},    32'(bus.misalign),       32'(mis));
        check({tag, ".count"},       32'(bus.redirect_count), 32'(cnt));
    endtask

    initial begin
        logic        ePc, eFl, eMis;
        logic [31:0] eRp;
        logic [15:0] eCnt;
        logic        r, v, j, st;
        logic [31:0] t;

        satRst = 1'b1;
        satEn  = 1'b0;
        drive(1, 1, 1, 32'h100, 0);

        //           rst v  j  target         st  pc rp            fl mis cnt
        vecs.push_back(mk(1, 1, 1, 32'h0000_0100, 0, 0, 32'h0,         0, 0, 0)); // reset quiet
        vecs.push_back(mk(0, 1, 1, 32'h0000_0100, 0, 1, 32'h0000_0100, 1, 0, 0)); // same-cycle redirect
        vecs.push_back(mk(0, 1, 1, 32'h0000_0300, 0, 0, 32'h0,         0, 0, 1)); // shadow 1
        vecs.push_back(mk(0, 1, 1, 32'h0000_0300, 1, 0, 32'h0,         0, 0, 1)); // stalled shadow
        vecs.push_back(mk(0, 1, 1, 32'h0000_0300, 0, 0, 32'h0,         0, 0, 1)); // shadow exit cycle
        vecs.push_back(mk(0, 1, 1, 32'h0000_0200, 1, 0, 32'h0,         0, 0, 1)); // stalled resolution
        vecs.push_back(mk(0, 1, 1, 32'h0000_0500, 1, 0, 32'h0,         0, 0, 1)); // held target wins
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0000_0200, 1, 0, 1)); // held redirect
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0102, 0, 0, 32'h0,         0, 1, 2)); // misaligned
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 2));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0102, 1, 0, 32'h0,         0, 0, 2)); // misaligned, stalled
        vecs.push_back(mk(0, 1, 1, 32'h0000_0300, 0, 1, 32'h0000_0300, 1, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 32'h0,         0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 3));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0400, 1, 0, 32'h0,         0, 0, 3)); // enter HOLD
        vecs.push_back(mk(1, 1, 1, 32'h0000_0400, 0, 0, 32'h0,         0, 0, 0)); // reset mid-HOLD
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0)); // held target dropped
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0104, 0, 1, 32'h0000_0104, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].j, vecs[i].t, vecs[i].st);
            @(negedge clk);
            checkOutputs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].rp, vecs[i].fl,
                         vecs[i].mis, vecs[i].cnt);
            @(posedge clk);
            #1;
        end

        // Randomized run against the model; first cycle resets both sides.
        for (int n = 0; n < 3000; n++) begin
            r  = (n == 0) || ($urandom_range(0, 99) < 2);
            v  = $urandom_range(0, 99) < 70;
            j  = $urandom_range(0, 99) < 60;
            st = $urandom_range(0, 99) < 30;
            t  = $urandom();
            if ($urandom_range(0, 99) < 80) t[1:0] = 2'b00;
            drive(r, v, j, t, st);
            modelCycle(r, v, j, t, st, ePc, eRp, eFl, eMis, eCnt);
            @(negedge clk);
            checkOutputs($sformatf("rnd%0d", n), ePc, eRp, eFl, eMis, eCnt);
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 32'h0, 0);

        // Saturation of the 16-bit counter, run two events past full scale.
        check("sat.reset", 32'(satCount), 32'h0);
        satRst = 1'b0;
        @(posedge clk);
        #1;
        check("sat.idle", 32'(satCount), 32'h0);
        satEn = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat.fffe", 32'(satCount), 32'hFFFE);
        @(posedge clk);
        #1;
        check("sat.ffff", 32'(satCount), 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        check("sat.hold", 32'(satCount), 32'hFFFF);
        satEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the PC redirect and the pipeline squash that follow a taken branch or jump resolved in EX. Consumes the jump controller's `shouldJump` and the computed target, then drives the PC mux select, the IF/ID and ID/EX flush strobes, and a misaligned-target flag. It sits between the EX-stage jump logic and the fetch/pipeline-register control. It also holds a pending redirect across memory stalls and blanks wrong-path resolutions for a fixed shadow window.

## Interface
- `XLEN`, 32, datapath/PC width.
- `SHADOW_CYCLES`, 2, unstalled cycles after a redirect during which EX resolutions are ignored; legal range 1..7.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ex_valid`  in  1  EX holds a valid, non-bubble instruction.
- `should_jump`  in  1  taken branch or jump from the jump controller.
- `ex_target`  in  XLEN  branch/jump target computed in EX.
- `stall`  in  1  pipeline frozen (memory busy); no stage advances.
- `pc_sel`  out  1  1 = next PC takes `redirect_pc`.
- `redirect_pc`  out  XLEN  redirect target; 0 when `pc_sel`=0.
- `flush_if_id`  out  1  squash the IF/ID register.
- `flush_id_ex`  out  1  squash the ID/EX register.
- `misalign`  out  1  one-cycle pulse: taken target not 4-byte aligned.
- `redirect_count`  out  16  saturating count of issued redirects.

## Operation
- A resolution is `ex_valid && should_jump`.
- The target is misaligned when `ex_target[1:0] != 2'b00`.
- States: IDLE, HOLD, SHADOW. The encoding is a 2-bit enum.
- **IDLE**
  - Resolution, aligned, `!stall`: issue the redirect this cycle (`pc_sel`=1, `redirect_pc`=`ex_target`, both flushes=1), then go to SHADOW.
  - Resolution, aligned, `stall`: latch `ex_target` into the hold register, drive no outputs, go to HOLD.
  - Resolution, misaligned: `misalign`=1 for that cycle (gated by `!stall`, so it pulses exactly once). No redirect, no flush, stay in IDLE.
- **HOLD**
  - While `stall`: all outputs 0. `ex_valid`/`should_jump` are ignored.
  - First cycle with `!stall`: issue the redirect from the hold register (same outputs as the IDLE issue), then go to SHADOW.
- **SHADOW**
  - Down-counter loaded with `SHADOW_CYCLES` on entry. It decrements only on `!stall` cycles.
  - Resolutions are ignored. Flushes stay 0.
  - Go to IDLE in the cycle after the counter reaches 0.
- `redirect_count` increments on every issued redirect, i.e. each cycle with `pc_sel`=1. It saturates at 16'hFFFF.
- Reset, asynchronous, including mid-HOLD or mid-SHADOW:
  - state goes to IDLE; hold register, shadow counter and `redirect_count` go to 0.
  - all outputs are 0 while `rst`=1.
  - a pending held redirect is discarded.

## Timing
- Unstalled resolution to redirect: 0 cycles. `pc_sel`, `redirect_pc` and the flushes are combinational from the inputs in IDLE and are asserted in the resolution cycle.
- Stalled resolution: the redirect is issued in the first `!stall` cycle, for exactly 1 cycle.
- Each issued redirect asserts `pc_sel` and both flushes for exactly 1 cycle.
- `redirect_count` updates at the edge ending the issue cycle.
- Minimum spacing between issued redirects: 1 + `SHADOW_CYCLES` unstalled cycles.
- `misalign` and a redirect are never asserted in the same cycle.
- Simultaneous cases:
  - resolution with `stall` in HOLD: ignored, the held target wins.
  - resolution in the cycle SHADOW exits to IDLE: ignored, because SHADOW is still the current state.

## Structure
- Shared defines/package:
  - state enum (IDLE=2'd0, HOLD=2'd1, SHADOW=2'd2);
  - `XLEN`;
  - the alignment mask constant.
- Sub-module: `sat_counter` (parameterised width, enable, async active-high reset, saturate at all-ones), instantiated for `redirect_count`. It is reusable for other performance counters.
- The state register, hold register and shadow counter stay in this module.

## Test plan
- Reset, then `ex_valid`=1, `should_jump`=1, `ex_target`=0x0000_0100, `stall`=0 → same cycle `pc_sel`=1, `redirect_pc`=0x100, both flushes=1; then SHADOW for 2 cycles; `redirect_count`=1.
- Resolution to 0x200 with `stall`=1 for 3 cycles → outputs 0 during the stall; on the first unstalled cycle, redirect to 0x200 for 1 cycle.
- Resolution to 0x0000_0102 → `misalign`=1 for one cycle; `pc_sel` and the flushes stay 0; count unchanged.
- Second resolution (to 0x300) on each SHADOW cycle, with `stall` toggling → no redirect; SHADOW lasts exactly 2 unstalled cycles; the next resolution after return to IDLE redirects.
- Assert `rst` mid-HOLD (held 0x400) → outputs 0 immediately; after release, no redirect to 0x400 and count=0.
- Force count to 0xFFFE via 2 more redirects than needed → saturates at 0xFFFF.
